// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the divide sequencer.
// Contents:
//   XLEN_DEFAULT   default datapath width
//   div_state_t    divide sequencer states
//   F3_*           funct3 encodings of the RV32M divide group
//   f3_is_div()    true for any divide-group funct3
package cpu_pkg;

    localparam int XLEN_DEFAULT = 32;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PREP = 3'd1,
        ITER = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } div_state_t;

    localparam logic [2:0] F3_DIV  = 3'b100;
    localparam logic [2:0] F3_DIVU = 3'b101;
    localparam logic [2:0] F3_REM  = 3'b110;
    localparam logic [2:0] F3_REMU = 3'b111;

    // Every divide-group encoding has bit 2 set; the other four codes are ignored.
    function automatic logic f3_is_div(input logic [2:0] f3);
        return f3[2];
    endfunction

endpackage

// File: rtl/div_sequencer_if.sv
// Bus between the EX-stage control and the divide sequencer.
// Handshake: start_i is held high by the pipeline for as long as stall_o is
// high; the operation completes when done_o pulses for one cycle, in which
// stall_o is low so the pipeline advances on that edge. flush_i aborts the
// in-flight instruction without a done_o.
// Signals:
//   start_i, funct3_i, a_i, b_i, flush_i   pipeline -> sequencer
//   stall_o, busy_o, done_o, result_o      sequencer -> pipeline
//   state_o                                FSM state (debug observation)
interface div_sequencer_if
    import cpu_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
);
    logic            start_i;
    logic [2:0]      funct3_i;
    logic [XLEN-1:0] a_i;
    logic [XLEN-1:0] b_i;
    logic            flush_i;
    logic            stall_o;
    logic            busy_o;
    logic            done_o;
    logic [XLEN-1:0] result_o;
    div_state_t      state_o;

    modport master (
        output start_i, funct3_i, a_i, b_i, flush_i,
        input  stall_o, busy_o, done_o, result_o, state_o
    );

    modport slave (
        input  start_i, funct3_i, a_i, b_i, flush_i,
        output stall_o, busy_o, done_o, result_o, state_o
    );
endinterface

// File: rtl/div_step.sv
// One combinational radix-2 restoring division step.
// Ports:
//   rem_i, quo_i   partial remainder and dividend/quotient shift register
//   divisor_i      divisor magnitude
//   rem_o, quo_o   values after shifting {rem,quo} left one and trial-subtracting
module div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem_i,
    input  logic [XLEN-1:0] quo_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic [XLEN-1:0] rem_o,
    output logic [XLEN-1:0] quo_o
);
    // The shifted remainder can reach 2*divisor-1, so both the shifted value
    // and the trial difference need XLEN+1 bits. Bit XLEN of the trial is
    // set exactly when the subtraction went negative.
    logic [XLEN:0] rem_sh;
    logic [XLEN:0] trial;

    assign rem_sh = {rem_i, quo_i[XLEN-1]};
    assign trial  = rem_sh - {1'b0, divisor_i};
    assign rem_o  = trial[XLEN] ? rem_sh[XLEN-1:0] : trial[XLEN-1:0];
    assign quo_o  = {quo_i[XLEN-2:0], ~trial[XLEN]};
endmodule

// File: rtl/div_sequencer.sv
// Multi-cycle RV32M divide/remainder sequencer beside the EX-stage ALU.
// Stalls the pipeline while a DIV/DIVU/REM/REMU runs XLEN restoring steps,
// applies RISC-V sign and corner-case rules, then pulses done_o with the
// result. Divide-by-zero and signed overflow finish one cycle after accept.
// Ports:
//   clk   system clock
//   rst   synchronous active-high reset
//   bus   div_sequencer_if slave modport (start/funct3/operands/flush in,
//         stall/busy/done/result/state out)
module div_sequencer
    import cpu_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    div_sequencer_if.slave bus
);
    localparam int CNT_W = $clog2(XLEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]  SMIN     = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0]  ONES     = '1;

    div_state_t      state, state_n;
    logic [XLEN-1:0] a_q, b_q, rem_q, quo_q, div_q, result_q;
    logic            signed_q, rem_sel_q, q_neg_q, r_neg_q;
    logic [CNT_W-1:0] cnt_q;

    logic            accept, special, f3_signed, busy;
    logic [XLEN-1:0] special_res, a_mag, b_mag, fix_quo, fix_rem;
    logic [XLEN-1:0] step_rem, step_quo;

    div_step #(.XLEN(XLEN)) u_step (
        .rem_i     (rem_q),
        .quo_i     (quo_q),
        .divisor_i (div_q),
        .rem_o     (step_rem),
        .quo_o     (step_quo)
    );

    // A flush in IDLE suppresses acceptance of a simultaneous start.
    assign accept    = (state == IDLE) & bus.start_i & f3_is_div(bus.funct3_i) & ~bus.flush_i;
    assign f3_signed = ~bus.funct3_i[0];
    assign special   = (bus.b_i == '0) |
                       (f3_signed & (bus.a_i == SMIN) & (bus.b_i == ONES));

    // Divide-by-zero: q = all ones, r = dividend. Overflow: q = MIN, r = 0.
    always_comb begin
        special_res = '0;
        if (bus.b_i == '0) special_res = bus.funct3_i[1] ? bus.a_i : ONES;
        else               special_res = bus.funct3_i[1] ? '0      : SMIN;
    end

    // Negating MIN yields MIN, which read as unsigned is the correct magnitude.
    assign a_mag   = (signed_q & a_q[XLEN-1]) ? -a_q : a_q;
    assign b_mag   = (signed_q & b_q[XLEN-1]) ? -b_q : b_q;
    assign fix_quo = q_neg_q ? -quo_q : quo_q;
    assign fix_rem = r_neg_q ? -rem_q : rem_q;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (accept) state_n = special ? DONE : PREP;
            PREP:    state_n = ITER;
            ITER:    if (cnt_q == '0) state_n = FIX;
            FIX:     state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (bus.flush_i && (state != IDLE)) state_n = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            div_q     <= '0;
            result_q  <= '0;
            signed_q  <= 1'b0;
            rem_sel_q <= 1'b0;
            q_neg_q   <= 1'b0;
            r_neg_q   <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state <= state_n;
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_q       <= bus.a_i;
                        b_q       <= bus.b_i;
                        signed_q  <= f3_signed;
                        rem_sel_q <= bus.funct3_i[1];
                        if (special) result_q <= special_res;
                    end
                end
                PREP: begin
                    quo_q   <= a_mag;
                    div_q   <= b_mag;
                    rem_q   <= '0;
                    cnt_q   <= CNT_LAST;
                    q_neg_q <= signed_q & (a_q[XLEN-1] ^ b_q[XLEN-1]);
                    r_neg_q <= signed_q & a_q[XLEN-1];
                end
                ITER: begin
                    rem_q <= step_rem;
                    quo_q <= step_quo;
                    cnt_q <= cnt_q - CNT_W'(1);
                end
                FIX: begin
                    // A flush here must leave the previous result visible.
                    if (!bus.flush_i) result_q <= rem_sel_q ? fix_rem : fix_quo;
                end
                default: ;
            endcase
        end
    end

    assign busy         = (state == PREP) | (state == ITER) | (state == FIX);
    assign bus.busy_o   = busy;
    assign bus.stall_o  = ~bus.flush_i & (accept | busy);
    assign bus.done_o   = (state == DONE) & ~bus.flush_i;
    assign bus.result_o = result_q;
    assign bus.state_o  = state;
endmodule
